// File: rtl/dest_reg_pkg.sv
// Shared definitions for the destination-register sequencer.
//   NUM_REGS_MAX / NUM_REGS_DEF : legal ceiling and default ring size
//   DIR_UP / DIR_DN             : step direction encodings
//   clog2()                     : elaboration-time index width helper
package dest_reg_pkg;

  localparam int unsigned NUM_REGS_MAX = 16;
  localparam int unsigned NUM_REGS_DEF = 8;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Bounded loop keeps this usable in synthesis as well as in parameters.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dest_reg_seq_if.sv
// Strobe/select bundle of the destination-register sequencer.
//   master : drives LDD, LDI, IDX, MASK, DIR; observes SEL, SEL_IDX, WRAP, EMPTY
//   slave  : the sequencer itself
interface dest_reg_seq_if
  import dest_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
);

  localparam int unsigned IDX_W = clog2(NUM_REGS);

  logic                LDD;
  logic                LDI;
  logic [IDX_W-1:0]    IDX;
  logic [NUM_REGS-1:0] MASK;
  logic                DIR;
  logic [NUM_REGS-1:0] SEL;
  logic [IDX_W-1:0]    SEL_IDX;
  logic                WRAP;
  logic                EMPTY;

  modport master (
    output LDD, LDI, IDX, MASK, DIR,
    input  SEL, SEL_IDX, WRAP, EMPTY
  );

  modport slave (
    input  LDD, LDI, IDX, MASK, DIR,
    output SEL, SEL_IDX, WRAP, EMPTY
  );

endinterface

// File: rtl/dest_reg_next.sv
// Combinational masked rotating search.
//   cur_i     : current index
//   mask_i    : per-register enable
//   dir_i     : DIR_UP / DIR_DN
//   nxt_o     : first enabled index after cur_i in the chosen direction (cur_i itself last)
//   wrapped_o : the winning step crossed the NUM_REGS-1 <-> 0 boundary
//   none_o    : mask_i is all zero; nxt_o then echoes cur_i
module dest_reg_next
  import dest_reg_pkg::*;
#(
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned IDX_W    = clog2(NUM_REGS)
) (
  input  logic [IDX_W-1:0]    cur_i,
  input  logic [NUM_REGS-1:0] mask_i,
  input  logic                dir_i,
  output logic [IDX_W-1:0]    nxt_o,
  output logic                wrapped_o,
  output logic                none_o
);

  // Pad the mask to the full index range so any IDX_W-bit select is in bounds.
  localparam int unsigned Span = 1 << IDX_W;

  logic [Span-1:0]  mask_ext;
  logic [IDX_W-1:0] cand;
  logic             wrap_k;
  logic             found;
  int               pos;

  assign mask_ext = Span'(mask_i);

  always_comb begin
    nxt_o     = cur_i;
    wrapped_o = 1'b0;
    none_o    = 1'b1;
    found     = 1'b0;
    pos       = 0;
    wrap_k    = 1'b0;
    cand      = '0;
    // Step k = NUM_REGS lands back on cur_i, so self-hold is the last candidate
    // and always counts as a wrap.
    for (int k = 1; k <= int'(NUM_REGS); k++) begin
      if (dir_i == DIR_UP) begin
        pos    = int'(cur_i) + k;
        wrap_k = (pos >= int'(NUM_REGS));
        if (wrap_k) pos = pos - int'(NUM_REGS);
      end else begin
        pos    = int'(cur_i) - k;
        wrap_k = (pos < 0);
        if (wrap_k) pos = pos + int'(NUM_REGS);
      end
      cand = pos[IDX_W-1:0];
      if (!found && mask_ext[cand]) begin
        found     = 1'b1;
        nxt_o     = cand;
        wrapped_o = wrap_k;
        none_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dest_reg_seq.sv
// Destination-register sequencer: holds the current destination index and
// steps it through a masked ring (LDD) or loads it directly (LDI).
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset
//   bus : dest_reg_seq_if slave -- strobes/IDX/MASK/DIR in,
//         registered SEL/SEL_IDX/WRAP out, combinational EMPTY out
module dest_reg_seq
  import dest_reg_pkg::*;
#(
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned IDX_W    = clog2(NUM_REGS)
) (
  input  logic           CLK,
  input  logic           RST,
  dest_reg_seq_if.slave  bus
);

  localparam logic [NUM_REGS-1:0] SelOne = NUM_REGS'(1);

  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [NUM_REGS-1:0] sel_q, sel_d;
  logic                wrap_q, wrap_d;

  logic [IDX_W-1:0]    nxt_idx;
  logic                nxt_wrapped;
  logic                nxt_none;

  dest_reg_next #(
    .NUM_REGS (NUM_REGS)
  ) u_next (
    .cur_i     (cur_q),
    .mask_i    (bus.MASK),
    .dir_i     (bus.DIR),
    .nxt_o     (nxt_idx),
    .wrapped_o (nxt_wrapped),
    .none_o    (nxt_none)
  );

  always_comb begin
    cur_d  = cur_q;
    wrap_d = 1'b0;
    if (bus.LDI) begin
      // Out-of-range direct loads clamp to the top register.
      if (int'(bus.IDX) < int'(NUM_REGS)) cur_d = bus.IDX;
      else                                 cur_d = IDX_W'(NUM_REGS - 1);
    end else if (bus.LDD && !nxt_none) begin
      cur_d  = nxt_idx;
      wrap_d = nxt_wrapped;
    end
    // One-hot kept as its own flop so SEL has no decode after the register.
    sel_d = SelOne << cur_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_q  <= '0;
      sel_q  <= SelOne;
      wrap_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      sel_q  <= sel_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.SEL     = sel_q;
  assign bus.SEL_IDX = cur_q;
  assign bus.WRAP    = wrap_q;
  assign bus.EMPTY   = ~|bus.MASK;

endmodule
